// File: rtl/popcount_sched_pkg.sv
// Shared definitions for the popcount scheduler.
//   LAT_DEF       default popcount pipeline latency (cycles, issue to count)
//   RES_DEPTH_DEF default result FIFO depth
//   N_REQ_DEF     default requester count; sizes the tag id field
//   tag_t         {valid, id, last}, travels beside the popcount pipeline
//   arb_state_t   arbiter states IDLE / LOCKED
package popcount_sched_pkg;

  localparam int LAT_DEF       = 6;
  localparam int RES_DEPTH_DEF = 4;
  localparam int N_REQ_DEF     = 4;
  localparam int TAG_ID_W      = $clog2(N_REQ_DEF);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } tag_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/popcount16_pipe.sv
// 16-input population count, path balanced as a registered adder tree.
//   clk    clock
//   din    16-bit word sampled every cycle (no handshake)
//   count  number of ones in the word presented LAT cycles earlier (0..16)
// The four tree levels take one cycle each; any remaining latency is a
// plain delay line on the 5-bit result. LAT must be at least 4.
module popcount16_pipe #(
  parameter int LAT = 6
) (
  input  logic        clk,
  input  logic [15:0] din,
  output logic [4:0]  count
);

  logic [1:0] s1 [8];
  logic [2:0] s2 [4];
  logic [3:0] s3 [2];
  logic [4:0] s4;

  for (genvar i = 0; i < 8; i++) begin : g_s1
    always_ff @(posedge clk) s1[i] <= {1'b0, din[2*i]} + {1'b0, din[2*i+1]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_s2
    always_ff @(posedge clk) s2[i] <= {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
  end

  for (genvar i = 0; i < 2; i++) begin : g_s3
    always_ff @(posedge clk) s3[i] <= {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
  end

  always_ff @(posedge clk) s4 <= {1'b0, s3[0]} + {1'b0, s3[1]};

  if (LAT == 4) begin : g_nodly
    assign count = s4;
  end else begin : g_dly
    logic [4:0] dly [LAT-4];
    always_ff @(posedge clk) dly[0] <= s4;
    for (genvar i = 1; i < LAT - 4; i++) begin : g_stage
      always_ff @(posedge clk) dly[i] <= dly[i-1];
    end
    assign count = dly[LAT-5];
  end

endmodule

// File: rtl/popcount_sched.sv
// Four-requester scheduler around a shared popcount pipeline.
//   clk, rst    clock, synchronous active-high reset
//   req_valid   per-requester word valid
//   req_last    per-requester last-word-of-burst marker
//   req_data    16 bits per requester, requester i on [16i+15:16i]
//   req_ready   per-requester accept
//   res_valid   result FIFO head valid
//   res_ready   consumer accept of the head
//   res_id      requester owning the head result
//   res_sum     popcount sum of the whole burst (wraps at ACC_W bits)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and ready may depend on valid.
// A round-robin arbiter grants whole bursts. A credit check counts bursts
// whose last word is in flight plus results already queued, so the FIFO
// can never overflow and the pipeline never needs to stall.
module popcount_sched
  import popcount_sched_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int LAT       = LAT_DEF,
  parameter int ACC_W     = 12,
  parameter int RES_DEPTH = RES_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [16*N_REQ-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [ACC_W-1:0]         res_sum
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int IFL_W = $clog2(LAT + 2);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  gnt_q, gnt_d, rr_q, rr_d, sel, cand;
  logic             sel_ok, issue, credit_ok;
  logic [15:0]      issue_data;
  tag_t             tag_in, tag_out;
  tag_t             tag_sr [LAT];
  logic [4:0]       count;
  logic [ACC_W-1:0] acc_q, acc_sum;
  logic             push, pop;
  logic [IFL_W-1:0] inflight_q;
  logic [CNT_W-1:0] fifo_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [ID_W-1:0]  mem_id  [RES_DEPTH];
  logic [ACC_W-1:0] mem_sum [RES_DEPTH];

  assign credit_ok = (int'(inflight_q) + int'(fifo_cnt)) < RES_DEPTH;

  // ---------------- arbiter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    sel        = gnt_q;
    sel_ok     = 1'b0;
    cand       = '0;
    req_ready  = '0;
    issue      = 1'b0;
    issue_data = '0;
    tag_in     = '0;
    if (state_q == IDLE) begin
      // Scan downward so the last hit is the closest index at/after rr_q.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = ID_W'((int'(rr_q) + k) % N_REQ);
        if (req_valid[cand]) begin
          sel    = cand;
          sel_ok = 1'b1;
        end
      end
    end else begin
      sel_ok = 1'b1;
    end
    if (sel_ok && credit_ok && !rst) req_ready[sel] = 1'b1;
    issue      = req_valid[sel] & req_ready[sel];
    issue_data = req_data[int'(sel)*16 +: 16];
    tag_in     = '{valid: issue, id: TAG_ID_W'(sel), last: issue & req_last[sel]};
    if (issue) begin
      if (req_last[sel]) begin
        state_d = IDLE;
        rr_d    = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
      end else begin
        state_d = LOCKED;
        gnt_d   = sel;
      end
    end
  end

  // ---------------- datapath and tag shadow ----------------
  popcount16_pipe #(.LAT(LAT)) u_pipe (
    .clk   (clk),
    .din   (issue_data),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) tag_sr[0] <= '0;
    else     tag_sr[0] <= tag_in;
  end

  for (genvar i = 1; i < LAT; i++) begin : g_tag
    always_ff @(posedge clk) begin
      if (rst) tag_sr[i] <= '0;
      else     tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign tag_out = tag_sr[LAT-1];

  // ---------------- accumulator and credit ----------------
  assign acc_sum = acc_q + ACC_W'(count);
  assign push    = tag_out.valid & tag_out.last;
  assign pop     = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      inflight_q <= '0;
    end else begin
      if (tag_out.valid) acc_q <= tag_out.last ? '0 : acc_sum;
      // Issue and completion of last words in one cycle cancel out.
      case ({tag_in.last, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // ---------------- result FIFO ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  for (genvar i = 0; i < RES_DEPTH; i++) begin : g_mem
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_id[i]  <= '0;
        mem_sum[i] <= '0;
      end else if (push && wr_ptr == PTR_W'(i)) begin
        mem_id[i]  <= ID_W'(tag_out.id);
        mem_sum[i] <= acc_sum;
      end
    end
  end

  assign res_valid = (fifo_cnt != '0);
  assign res_id    = mem_id[rd_ptr];
  assign res_sum   = mem_sum[rd_ptr];

endmodule
